// File: rtl/memory_master.sv
// memory_master: single-outstanding host-to-memory-line master with optional write read-back verify
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   req_valid/req_ready          host request handshake (ready only when idle)
//   req_write, req_addr, req_wdata   request type, line index, write data
//   rsp_valid/rsp_ready          read response handshake, rsp_rdata holds captured data
//   mem_select, mem_rE, mem_wE, mem_wdata   one-hot line strobes and write data
//   mem_rdata                    shared combinational read bus from the lines
//   wr_error                     sticky write-verify mismatch flag
//
// Build option: define MEMORY_MASTER_WRITE_VERIFY_EN to read every written line
// back in a VERIFY cycle; otherwise wr_error is tied to 0.
module memory_master #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic [(2**ADDR_WIDTH)-1:0] mem_select,
  output logic                       mem_rE,
  output logic                       mem_wE,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       wr_error
);
  localparam int LINES = 2**ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, READ, RESP} state_t;
`ifdef MEMORY_MASTER_WRITE_VERIFY_EN
  localparam state_t AFTER_WRITE = VERIFY;
`else
  localparam state_t AFTER_WRITE = IDLE;
`endif
  state_t                state_q, state_d;
  logic                  accept, strobe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LINES-1:0]      select_q;
  logic                  re_q, we_q, rsp_valid_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  assign accept   = state_q == IDLE && req_valid;
  assign addr_d   = accept ? req_addr : addr_q;
  assign data_d   = accept ? req_wdata : data_q;
  always_comb begin
    state_d = state_q == IDLE  ? (req_valid ? (req_write ? WRITE : READ) : IDLE) :
              state_q == WRITE ? AFTER_WRITE :
              state_q == READ  ? RESP :
              state_q == RESP  ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  // Strobes are registered from the next state so they line up exactly with the state cycle.
  assign strobe_d = state_d == WRITE || state_d == VERIFY || state_d == READ;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      select_q    <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      select_q    <= strobe_d ? {{(LINES-1){1'b0}}, 1'b1} << addr_d : '0;
      re_q        <= state_d == READ || state_d == VERIFY;
      we_q        <= state_d == WRITE;
      wdata_q     <= state_d == WRITE ? data_d : '0;
      rsp_valid_q <= state_d == RESP;
      rdata_q     <= state_q == READ ? mem_rdata : rdata_q;
    end
  end
`ifdef MEMORY_MASTER_WRITE_VERIFY_EN
  logic wr_error_q;
  always_ff @(posedge clock) begin
    if (reset) wr_error_q <= 1'b0;
    else if (state_q == VERIFY && mem_rdata != data_q) wr_error_q <= 1'b1;
  end
  assign wr_error = wr_error_q;
`else
  assign wr_error = 1'b0;
`endif
  assign req_ready  = state_q == IDLE;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign mem_select = select_q;
  assign mem_rE     = re_q;
  assign mem_wE     = we_q;
  assign mem_wdata  = wdata_q;
endmodule

// File: tb/tb_memory_master.sv
// tb_memory_master: scoreboard bench for memory_master with a 4-line memory model
module tb_memory_master;
`ifdef MEMORY_MASTER_WRITE_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif
  logic       clock = 1'b0, reset = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, mem_rE, mem_wE, wr_error;
  logic [7:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_select;
  logic [7:0] mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       corrupt = 1'b0;
  logic [7:0] exp_q [$];
  int         n_vec = 0, n_err = 0, strobe_bad = 0, sel_cycles = 0;

  memory_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_select(mem_select), .mem_rE(mem_rE), .mem_wE(mem_wE),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wr_error(wr_error)
  );

  always #5 clock = ~clock;

  // Memory lines: line 1 stores inverted data while corrupt is set.
  always @(posedge clock)
    for (int i = 0; i < 4; i++)
      if (mem_wE && mem_select[i]) mem[i] <= (corrupt && i == 1) ? ~mem_wdata : mem_wdata;
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (mem_rE && mem_select[i]) mem_rdata = mem_rdata | mem[i];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clock) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_rdata", rsp_rdata, exp_q.pop_front());
    end
  end

  // Strobe monitor runs for the whole simulation.
  always @(negedge clock) begin
    if (mem_rE && mem_wE) strobe_bad++;
    if (!$onehot0(mem_select)) strobe_bad++;
    if (!mem_rE && !mem_wE && mem_select != 0) strobe_bad++;
    if (mem_select != 0) sel_cycles++;
  end

  // Issue one request; returns just after its acceptance edge.
  task automatic do_req(input bit wr, input logic [1:0] a, input logic [7:0] d,
                        input bit push, input bit rnd);
    int t = 0;
    while (!req_ready && t < 50) begin
      if (rnd) rsp_ready = $urandom_range(0, 3) != 0;
      @(posedge clock); #1;
      t++;
    end
    if (!req_ready) check("req_ready_timeout", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    if (wr) exp_mem[a] = (corrupt && a == 1) ? ~d : d;
    else if (push) exp_q.push_back(exp_mem[a]);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clock); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    step; step;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_select", mem_select, 0);
    check("rst_strobes", {mem_rE, mem_wE}, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_wr_error", wr_error, 0);
    reset = 1'b0;
    step;
    check("rst_req_ready", req_ready, 1);

    // Write addr 2 = A5, then read it back.
    do_req(1, 2'd2, 8'hA5, 0, 0);
    @(negedge clock);
    check("wr_select", mem_select, 4'b0100);
    check("wr_we_re", {mem_wE, mem_rE}, 2'b10);
    check("wr_wdata", mem_wdata, 8'hA5);
    step;
    check("wr_once", mem_wE, 0);
    check("wr_throughput_ready", req_ready, !VERIFY_EN);
    do_req(0, 2'd2, 8'h00, 1, 0);
    @(negedge clock);
    check("rd_select", mem_select, 4'b0100);
    check("rd_re_we", {mem_rE, mem_wE}, 2'b10);
    @(negedge clock);
    check("rd_latency", rsp_valid, 1);
    check("rd_data_A5", rsp_rdata, 8'hA5);
    step;

    // Backpressure: response held for 5 cycles.
    rsp_ready = 1'b0;
    do_req(0, 2'd2, 8'h00, 1, 0);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, 8'hA5);
      check("bp_ready", req_ready, 0);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    step;
    check("bp_idle", req_ready, 1);
    check("bp_valid_drop", rsp_valid, 0);

    // Reset in the READ cycle discards the response.
    do_req(0, 2'd3, 8'h00, 0, 0);
    @(negedge clock);
    check("mr_read_cycle", mem_rE, 1);
    reset = 1'b1;
    step;
    check("mr_strobes", {mem_rE, mem_wE}, 0);
    check("mr_select", mem_select, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    step;
    check("mr_req_ready", req_ready, 1);
    check("mr_no_rsp", rsp_valid, 0);

    // Request held while busy is only taken once idle.
    s0 = sel_cycles;
    rsp_ready = 1'b0;
    do_req(0, 2'd0, 8'h00, 1, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
    @(negedge clock);
    check("busy_sel0", mem_select, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("busy_no_accept", req_ready, 0);
      check("busy_no_sel", mem_select, 0);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    exp_q.push_back(exp_mem[3]);
    step;
    check("busy_idle", req_ready, 1);
    step;
    req_valid = 1'b0;
    @(negedge clock);
    check("busy_sel3", mem_select, 4'b1000);
    step; step;
    check("busy_sel_count", sel_cycles - s0, 2);
    check("busy_data_3", exp_mem[3], 8'h44);

    // Write verify on a corrupting line.
    corrupt = 1'b1;
    do_req(1, 2'd1, 8'h3C, 0, 0);
    @(negedge clock);
    check("wv_write", {mem_wE, mem_select}, 5'b1_0010);
    step;
`ifdef MEMORY_MASTER_WRITE_VERIFY_EN
    check("wv_verify", {mem_rE, mem_wE, mem_select}, 6'b10_0010);
    step;
`endif
    check("wv_error", wr_error, VERIFY_EN);
    corrupt = 1'b0;
    do_req(1, 2'd0, 8'h5A, 0, 0);
    do_req(1, 2'd1, 8'h77, 0, 0);
    step; step;
    check("wv_sticky", wr_error, VERIFY_EN);
    do_req(0, 2'd1, 8'h00, 1, 0);
    step; step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("wv_cleared", wr_error, 0);
    step;

    // Random stream for strobe exclusivity.
    for (int i = 0; i < 600; i++)
      do_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom), 1, 1);
    rsp_ready = 1'b1;
    repeat (6) step;
    check("rand_wr_error", wr_error, 0);
    check("strobe_exclusive", strobe_bad, 0);
    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
